// File: rtl/calc_pkg.sv
// Shared calculator definitions: result width, display digit count and the
// result_to_bcd FSM state type.
package calc_pkg;

  localparam int RESULT_W   = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction stage: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd5) ? (in + 4'd3) : in;

endmodule

// File: rtl/result_to_bcd.sv
// Sequential binary-to-BCD decoder for the calculator result path: sign flag,
// DIGITS BCD digits and a leading-zero blank mask, one bit per clock.
module result_to_bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                negative,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank,
  output state_t              state
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  // Handshake: start/value are taken on any rising edge where state is IDLE;
  // start while busy is dropped. done pulses for exactly one cycle, in which
  // bcd/negative/blank already hold the new result and state is IDLE again,
  // so a start in the done cycle is accepted.

  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     scratch;
  logic              neg;

  logic [WIDTH-1:0]  value_mag;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_next;
  logic [WIDTH-1:0]  mag_next;
  logic [DIGITS-1:0] blank_next;
  logic              all_zero;
  logic              last_iter;

  // Two's-complement magnitude; the most negative value maps onto its own
  // unsigned bit pattern, which is the correct magnitude.
  assign value_mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .in  (scratch[4*g +: 4]),
      .out (adj[4*g +: 4])
    );
  end

  assign scratch_next = {adj[BW-2:0], mag[WIDTH-1]};
  assign mag_next     = {mag[WIDTH-2:0], 1'b0};
  assign last_iter    = (cnt == CW'(WIDTH - 1));
  assign busy         = (state == SHIFT);

  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (scratch_next[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      mag      <= '0;
      scratch  <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
      negative <= 1'b0;
      bcd      <= '0;
      blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg     <= value[WIDTH-1];
            mag     <= value_mag;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          mag     <= mag_next;
          cnt     <= cnt + CW'(1);
          if (last_iter) begin
            bcd      <= scratch_next;
            negative <= neg;
            blank    <= blank_next;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
